channel_scheduler: RTL and testbench
====================================

CHANNEL_SCHEDULER -- requirements
Module: channel_scheduler

Interface
REQ-001 SHALL have parameter MAX_CHAN_COUNT, default 10, number of scope channels.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 8, bits per sample.
REQ-003 SHALL have parameter DEPTH, default 640, samples per channel buffer; ADDR_W = $clog2(DEPTH).
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system/pixel clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 vblank  input  1  vertical blanking level from VGA timing.
REQ-008 enable_toggle  input  MAX_CHAN_COUNT  one-cycle pulse per channel, toggles that channel's pending enable.
REQ-009 sample_req  input  MAX_CHAN_COUNT  per-channel write request, held high until granted.
REQ-010 sample_data  input  MAX_CHAN_COUNT*SAMPLE_WIDTH  channel k data at bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
REQ-011 channel_enable  output  MAX_CHAN_COUNT  active mask, drives display row mapper.
REQ-012 grant  output  MAX_CHAN_COUNT  one-hot, high one cycle per accepted write.
REQ-013 wr_en  output  1  sample memory write strobe.
REQ-014 wr_chan  output  $clog2(MAX_CHAN_COUNT)  channel index of write.
REQ-015 wr_addr  output  ADDR_W  per-channel write pointer value.
REQ-016 wr_data  output  SAMPLE_WIDTH  granted channel's sample.
REQ-017 frame_update  output  1  one-cycle pulse when new mask applied.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, APPLY.
REQ-019 pending mask SHALL update every cycle as pending ^ enable_toggle, independent of state.
REQ-020 IDLE SHALL go to APPLY on vblank rising edge (registered vblank 0->1) when pending != channel_enable; APPLY takes priority over arbitration in same cycle.
REQ-021 IDLE SHALL otherwise, if (sample_req & channel_enable) != 0, latch winner and its data and go to WRITE.
REQ-022 WRITE SHALL last exactly one cycle: wr_en=1, grant one-hot at winner, wr_chan/wr_addr/wr_data valid, then go to IDLE; throughput one write per 2 cycles.
REQ-023 Winner's write pointer SHALL increment after WRITE, wrapping DEPTH-1 -> 0.
REQ-024 Round-robin: search SHALL start at last winner + 1 (mod MAX_CHAN_COUNT); search start after reset is channel 0.
REQ-025 Requests from channels disabled in channel_enable SHALL never be granted.
REQ-026 APPLY SHALL last one cycle: channel_enable <= pending value latched on entry, frame_update=1, write pointers of newly enabled channels (0->1) cleared to 0, then IDLE.
REQ-027 Toggle pulses in the APPLY cycle SHALL affect pending only, not the applied mask.
REQ-028 vblank edge arriving while in WRITE SHALL be serviced in the next IDLE cycle if vblank still high (edge held as flag until serviced or vblank falls).
REQ-029 grant, wr_en, frame_update SHALL be 0 in all states except those specified.

Reset
REQ-030 On rst_n=0: state IDLE, channel_enable = all ones, pending = all ones, all write pointers 0, round-robin start 0, grant/wr_en/frame_update/wr_chan/wr_addr/wr_data = 0.
REQ-031 Reset assertion mid-WRITE or mid-APPLY SHALL abort immediately with outputs at reset values.

Configuration
REQ-032 Macro CHAN_SCHED_FIXED_PRIO_EN: defined -> winner is lowest-index enabled requester, round-robin pointer removed; undefined -> round-robin per REQ-024.

Verification
REQ-033 Reset, then sample_req=10'h3FF held: grants in order ch0,1,...,9,0 every 2 cycles (fixed-prio build: ch0 always).
REQ-034 enable_toggle=10'h002 pulse, no vblank: channel_enable stays 10'h3FF; on next vblank rise -> 10'h3FD, frame_update 1 cycle; ch1 requests no longer granted.
REQ-035 ch3 only requesting, DEPTH=640: 640 writes give wr_addr 0..639, 641st write wr_addr=0.
REQ-036 Disable ch2 at vblank, write 5 samples on ch2 beforehand, re-enable at next vblank: first ch2 write after re-enable has wr_addr=0.
REQ-037 vblank rises while in WRITE with sample_req pending: APPLY occurs before next WRITE; toggle pulsed in APPLY cycle appears only at following vblank.
REQ-038 Assert rst_n=0 during WRITE: wr_en and grant low same cycle, channel_enable=10'h3FF.

Source files
------------

// File: rtl/channel_scheduler.sv
// Scope channel write scheduler: arbitrates per-channel sample writes and applies enable-mask changes at vblank.
// Build option CHAN_SCHED_FIXED_PRIO_EN selects lowest-index-wins arbitration instead of round-robin.
module channel_scheduler #(
  parameter int MAX_CHAN_COUNT = 10,
  parameter int SAMPLE_WIDTH   = 8,
  parameter int DEPTH          = 640,
  localparam int ADDR_W        = $clog2(DEPTH),
  localparam int CHAN_W        = $clog2(MAX_CHAN_COUNT)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   vblank,
  input  logic [MAX_CHAN_COUNT-1:0]              enable_toggle,
  input  logic [MAX_CHAN_COUNT-1:0]              sample_req,
  input  logic [MAX_CHAN_COUNT*SAMPLE_WIDTH-1:0] sample_data,
  output logic [MAX_CHAN_COUNT-1:0]              channel_enable,
  output logic [MAX_CHAN_COUNT-1:0]              grant,
  output logic                                   wr_en,
  output logic [CHAN_W-1:0]                      wr_chan,
  output logic [ADDR_W-1:0]                      wr_addr,
  output logic [SAMPLE_WIDTH-1:0]                wr_data,
  output logic                                   frame_update
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] APPLY = 2'd2;

  logic [1:0]                state;
  logic [MAX_CHAN_COUNT-1:0] pending;
  logic                      vblank_q;
  logic                      vb_flag;
  logic [ADDR_W-1:0]         wr_ptr [MAX_CHAN_COUNT];
  logic [MAX_CHAN_COUNT-1:0] eligible;
  logic [CHAN_W-1:0]         win_idx;
  logic                      win_found;
  logic                      vb_rise;
  logic                      vb_event;
  logic                      do_apply;

`ifndef CHAN_SCHED_FIXED_PRIO_EN
  logic [CHAN_W-1:0]         rr_start;
`endif

  assign eligible = sample_req & channel_enable;
  assign vb_rise  = vblank & ~vblank_q;
  // An edge seen during WRITE/APPLY stays live in vb_flag until IDLE consumes it or vblank drops.
  assign vb_event = vblank & (vb_rise | vb_flag);
  assign do_apply = (state == IDLE) && vb_event && (pending != channel_enable);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef CHAN_SCHED_FIXED_PRIO_EN
    for (int unsigned i = 0; i < MAX_CHAN_COUNT; i++) begin
      if (!win_found && eligible[i]) begin
        win_found = 1'b1;
        win_idx   = CHAN_W'(i);
      end
    end
`else
    for (int unsigned i = 0; i < MAX_CHAN_COUNT; i++) begin
      int unsigned idx;
      idx = int'(rr_start) + i;
      if (idx >= MAX_CHAN_COUNT) idx = idx - MAX_CHAN_COUNT;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = CHAN_W'(idx);
      end
    end
`endif
  end

  assign wr_en        = (state == WRITE);
  assign frame_update = (state == APPLY);
  assign grant        = {{(MAX_CHAN_COUNT-1){1'b0}}, wr_en} << wr_chan;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pending        <= '1;
      channel_enable <= '1;
      vblank_q       <= 1'b0;
      vb_flag        <= 1'b0;
      wr_chan        <= '0;
      wr_addr        <= '0;
      wr_data        <= '0;
`ifndef CHAN_SCHED_FIXED_PRIO_EN
      rr_start       <= '0;
`endif
      for (int unsigned i = 0; i < MAX_CHAN_COUNT; i++) wr_ptr[i] <= '0;
    end else begin
      pending  <= pending ^ enable_toggle;
      vblank_q <= vblank;
      if (!vblank || state == IDLE) vb_flag <= 1'b0;
      else if (vb_rise)             vb_flag <= 1'b1;

      case (state)
        IDLE: begin
          if (do_apply) begin
            // Mask is applied on entry so it is already visible during the frame_update cycle.
            channel_enable <= pending;
            for (int unsigned i = 0; i < MAX_CHAN_COUNT; i++)
              if (pending[i] && !channel_enable[i]) wr_ptr[i] <= '0;
            state <= APPLY;
          end else if (win_found) begin
            wr_chan <= win_idx;
            wr_addr <= wr_ptr[win_idx];
            wr_data <= sample_data[int'(win_idx)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            state   <= WRITE;
          end
        end
        WRITE: begin
          wr_ptr[wr_chan] <= (wr_addr == ADDR_W'(DEPTH-1)) ? '0 : wr_addr + 1'b1;
`ifndef CHAN_SCHED_FIXED_PRIO_EN
          rr_start <= (wr_chan == CHAN_W'(MAX_CHAN_COUNT-1)) ? '0 : wr_chan + 1'b1;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_scheduler.sv
// Bench for channel_scheduler: directed scenarios plus random traffic, every cycle compared
// against a transaction-level model of pending/enable masks, per-channel pointers and arbitration.
module tb_channel_scheduler;
  localparam int N     = 10;
  localparam int SW    = 8;
  localparam int DEPTH = 640;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            vblank;
  logic [N-1:0]    enable_toggle;
  logic [N-1:0]    sample_req;
  logic [N*SW-1:0] sample_data;
  logic [N-1:0]    channel_enable;
  logic [N-1:0]    grant;
  logic            wr_en;
  logic [CW-1:0]   wr_chan;
  logic [AW-1:0]   wr_addr;
  logic [SW-1:0]   wr_data;
  logic            frame_update;

  channel_scheduler #(.MAX_CHAN_COUNT(N), .SAMPLE_WIDTH(SW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .vblank(vblank), .enable_toggle(enable_toggle),
    .sample_req(sample_req), .sample_data(sample_data), .channel_enable(channel_enable),
    .grant(grant), .wr_en(wr_en), .wr_chan(wr_chan), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_update(frame_update)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: masks, pointers, next round-robin start, and which one-cycle action is under way.
  logic [N-1:0]  m_en, m_pend;
  int            m_ptr [N];
  int            m_next;
  bit            m_vq, m_flag, m_wr, m_ap;
  int            m_wchan, m_waddr;
  logic [SW-1:0] m_wdata;

  function automatic void model_reset();
    m_en = '1; m_pend = '1; m_next = 0;
    m_vq = 0; m_flag = 0; m_wr = 0; m_ap = 0;
    m_wchan = 0; m_waddr = 0; m_wdata = '0;
    for (int i = 0; i < N; i++) m_ptr[i] = 0;
  endfunction

  task automatic model_step();
    bit rise, ev, found;
    logic [N-1:0] elig;
    int k;
    rise = vblank && !m_vq;
    if (!m_wr && !m_ap) begin
      ev   = vblank && (rise || m_flag);
      elig = sample_req & m_en;
      if (ev && m_pend != m_en) begin
        for (int i = 0; i < N; i++) if (m_pend[i] && !m_en[i]) m_ptr[i] = 0;
        m_en = m_pend;
        m_ap = 1;
      end else if (elig != '0) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          k = (m_next + i) % N;
          if (!found && elig[k]) begin found = 1; m_wchan = k; end
        end
        m_waddr = m_ptr[m_wchan];
        m_wdata = sample_data[m_wchan*SW +: SW];
        m_wr    = 1;
      end
      m_flag = 0;
    end else begin
      if (m_wr) begin
        m_ptr[m_wchan] = (m_ptr[m_wchan] + 1) % DEPTH;
`ifndef CHAN_SCHED_FIXED_PRIO_EN
        m_next = (m_wchan + 1) % N;
`endif
        m_wr = 0;
      end
      m_ap   = 0;
      m_flag = vblank && (m_flag || rise);
    end
    m_pend = m_pend ^ enable_toggle;
    m_vq   = vblank;
  endtask

  task automatic compare_outputs();
    logic [N-1:0] g;
    g = m_wr ? (N'(1) << m_wchan) : '0;
    check("channel_enable", channel_enable, m_en);
    check("wr_en", wr_en, m_wr);
    check("frame_update", frame_update, m_ap);
    check("grant", grant, g);
    if (m_wr) begin
      check("wr_chan", wr_chan, m_wchan);
      check("wr_addr", wr_addr, m_waddr);
      check("wr_data", wr_data, m_wdata);
    end
  endtask

  task automatic cycle(input bit vb, input logic [N-1:0] tog, input logic [N-1:0] req);
    logic [95:0] r;
    @(posedge clk);
    #1;
    r = {$urandom(), $urandom(), $urandom()};
    vblank = vb; enable_toggle = tog; sample_req = req; sample_data = r[N*SW-1:0];
    @(negedge clk);
    compare_outputs();
    model_step();
  endtask

  task automatic do_reset();
    rst_n = 0; vblank = 0; enable_toggle = '0; sample_req = '0; sample_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1;
  endtask

  int n, exp_ch, guard;
  bit vb_r;
  logic [N-1:0] tog_r;

  initial begin
    do_reset();
    check("rst_enable", channel_enable, 10'h3FF);
    check("rst_grant", grant, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_frame_update", frame_update, 0);
    check("rst_wr_chan", wr_chan, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);

    // All channels requesting: one grant per two cycles in arbitration order.
    n = 0; exp_ch = 0;
    repeat (22) begin
      cycle(0, '0, 10'h3FF);
      if (wr_en) begin
        check("rr_order", wr_chan, exp_ch);
        n++;
`ifndef CHAN_SCHED_FIXED_PRIO_EN
        exp_ch = (exp_ch + 1) % N;
`endif
      end
    end
    check("rr_count", n, 11);

    // Toggle waits for vblank, then disables ch1.
    cycle(0, 10'h002, '0);
    repeat (3) cycle(0, '0, '0);
    check("no_apply_before_vblank", channel_enable, 10'h3FF);
    cycle(1, '0, '0);
    cycle(1, '0, '0);
    check("apply_mask", channel_enable, 10'h3FD);
    check("apply_pulse", frame_update, 1);
    cycle(1, '0, 10'h002);
    check("pulse_one_cycle", frame_update, 0);
    repeat (6) cycle(0, '0, 10'h002);

    // Pointer cleared when a channel is re-enabled.
    do_reset();
    repeat (10) cycle(0, '0, 10'h004);
    cycle(0, 10'h004, '0);
    cycle(1, '0, '0);
    cycle(1, '0, '0);
    check("ch2_disabled", channel_enable, 10'h3FB);
    cycle(0, '0, '0);
    cycle(0, 10'h004, '0);
    cycle(1, '0, '0);
    cycle(1, '0, '0);
    check("ch2_reenabled", channel_enable, 10'h3FF);
    guard = 0;
    do begin cycle(0, '0, 10'h004); guard++; end while (!wr_en && guard < 4);
    check("reenable_seen", wr_en, 1);
    check("reenable_addr", wr_addr, 0);

    // Single requester on ch3: pointer sweeps the whole buffer and wraps.
    do_reset();
    n = 0; guard = 0;
    while (n < 641 && guard < 1400) begin
      cycle(0, '0, 10'h008);
      guard++;
      if (wr_en) begin
        check("wrap_addr", wr_addr, n % DEPTH);
        n++;
      end
    end
    check("wrap_count", n, 641);

    // vblank edge during WRITE is serviced before the next WRITE; APPLY-cycle toggle is deferred.
    do_reset();
    cycle(0, 10'h020, '0);
    cycle(0, '0, 10'h3FF);
    cycle(1, '0, 10'h3FF);
    check("edge_in_write", wr_en, 1);
    cycle(1, '0, 10'h3FF);
    check("idle_after_write", wr_en, 0);
    cycle(1, 10'h020, 10'h3FF);
    check("late_apply_pulse", frame_update, 1);
    check("late_apply_mask", channel_enable, 10'h3DF);
    cycle(1, '0, 10'h3FF);
    check("apply_toggle_deferred", channel_enable, 10'h3DF);
    cycle(0, '0, 10'h3FF);
    cycle(0, '0, 10'h3FF);
    cycle(1, '0, 10'h3FF);
    guard = 0;
    do begin cycle(1, '0, 10'h3FF); guard++; end while (!frame_update && guard < 4);
    check("deferred_toggle_applied", channel_enable, 10'h3FF);

    // Reset asserted in the middle of a WRITE cycle.
    guard = 0;
    do begin cycle(0, '0, 10'h3FF); guard++; end while (!wr_en && guard < 4);
    check("write_before_reset", wr_en, 1);
    rst_n = 0;
    #1;
    check("abort_wr_en", wr_en, 0);
    check("abort_grant", grant, 0);
    check("abort_enable", channel_enable, 10'h3FF);
    check("abort_wr_addr", wr_addr, 0);
    vblank = 0; enable_toggle = '0; sample_req = '0;
    model_reset();
    #2 rst_n = 1;

    // Random traffic.
    vb_r = 0;
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) vb_r = !vb_r;
      tog_r = ($urandom_range(0, 7) == 0) ? (N'(1) << $urandom_range(0, N-1)) : '0;
      cycle(vb_r, tog_r, N'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
